// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared types for the data-memory responder
package vliw_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_req_fifo.sv
// rtl/dmem_req_fifo.sv - request buffer in front of the responder FSM
module dmem_req_fifo
  import vliw_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  dmem_req_t din_i,
  input  logic      pop_i,
  output dmem_req_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  dmem_req_t   slot_q [FIFO_DEPTH];
  logic [PW:0] wr_q, wr_d;
  logic [PW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + {{PW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{PW{1'b0}}, do_pop};
  assign dout_o  = slot_q[rd_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      slot_q[wr_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - buffered fixed-latency data memory for the LSU
// Optional misaligned-access error reporting: define DMEM_MISALIGN_ERR_EN.
module dmem_responder
  import vliw_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_is_store,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   cur_q, cur_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_store_q, is_store_d;
  logic        err_q, err_d;

  dmem_req_t   fifo_din;
  dmem_req_t   fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic        misal;
  logic        mem_we;
  logic        unused_addr_bits;

  assign fifo_din  = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;

  dmem_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (req_valid),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Upper address bits alias onto the array so accesses wrap.
  assign idx              = cur_q.addr[AW+1:2];
  assign unused_addr_bits = ^{cur_q.addr[31:AW+2], cur_q.addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  assign misal = |cur_q.addr[1:0];
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          cnt_d    = CNT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we     = cur_q.we && !misal;
          is_store_d = cur_q.we;
          err_d      = misal;
          rdata_d    = (cur_q.we || misal) ? 32'd0 : mem[idx];
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cur_q      <= '0;
      rdata_q    <= 32'd0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= cur_q.wdata;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_is_store = is_store_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_is_store;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_is_store(rsp_is_store),
    .rsp_err     (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // exp_lat of 0 skips the latency check (used when draining a backlog).
  task automatic expect_rsp(input string tag, input int exp_lat, input logic exp_store,
                            input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (exp_lat != 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_is_store"}, {31'd0, rsp_is_store}, {31'd0, exp_store});
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_is_store", {31'd0, rsp_is_store}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // store then load of the same word, each responding LATENCY+1 edges after accept
    send("st10", 1'b1, 32'h10, 32'hDEADBEEF);
    expect_rsp("st10", LAT + 1, 1'b1, 32'h0, 1'b0);
    send("ld10", 1'b0, 32'h10, 32'h0);
    expect_rsp("ld10", LAT + 1, 1'b0, 32'hDEADBEEF, 1'b0);

    // back-to-back requests with the LSU stalling responses
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    check("b2b_ready0", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h12345678;
    check("b2b_ready1", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_we = 1'b0; req_addr = 32'h14; req_wdata = 32'h0;
    check("b2b_ready2", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("b2b_full", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold_full", {31'd0, req_ready}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    expect_rsp("drain0", 0, 1'b0, 32'hDEADBEEF, 1'b0);
    expect_rsp("drain1", 0, 1'b1, 32'h0, 1'b0);
    expect_rsp("drain2", 0, 1'b0, 32'h12345678, 1'b0);
    check("drain_ready", {31'd0, req_ready}, 32'd1);

    // address wrap: 0x400 aliases word 0 in a 256-word array
    send("st400", 1'b1, 32'h400, 32'h55);
    expect_rsp("st400", LAT + 1, 1'b1, 32'h0, 1'b0);
    send("ld000", 1'b0, 32'h0, 32'h0);
    expect_rsp("ld000", LAT + 1, 1'b0, 32'h55, 1'b0);

    // reset during WAIT of a store must not disturb memory
    send("st20", 1'b1, 32'h20, 32'h1);
    expect_rsp("st20", LAT + 1, 1'b1, 32'h0, 1'b0);
    send("ld20a", 1'b0, 32'h20, 32'h0);
    expect_rsp("ld20a", LAT + 1, 1'b0, 32'h1, 1'b0);
    send("st20bad", 1'b1, 32'h20, 32'hBAD0BAD0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    check("midrst_is_store", {31'd0, rsp_is_store}, 32'd0);
    check("midrst_err", {31'd0, rsp_err}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    check("postrst_idle_valid", {31'd0, rsp_valid}, 32'd0);
    send("ld20b", 1'b0, 32'h20, 32'h0);
    expect_rsp("ld20b", LAT + 1, 1'b0, 32'h1, 1'b0);

    // misaligned store to 0x13 against word 0x10 (holds 0xDEADBEEF)
    send("st13", 1'b1, 32'h13, 32'hA5A5A5A5);
`ifdef DMEM_MISALIGN_ERR_EN
    expect_rsp("st13", LAT + 1, 1'b1, 32'h0, 1'b1);
    send("ld10m", 1'b0, 32'h10, 32'h0);
    expect_rsp("ld10m", LAT + 1, 1'b0, 32'hDEADBEEF, 1'b0);
`else
    expect_rsp("st13", LAT + 1, 1'b1, 32'h0, 1'b0);
    send("ld10m", 1'b0, 32'h10, 32'h0);
    expect_rsp("ld10m", LAT + 1, 1'b0, 32'hA5A5A5A5, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
